lcd_frame_loader: RTL and testbench
===================================

// Module: lcd_frame_loader
// PURPOSE
//  Upstream feeder for the LCD_TEST character display. Accepts a byte stream
//  (UART RX / debug bus) over a valid/ready handshake, assembles a 12-byte
//  frame in a shadow buffer, and commits it atomically to the 12 held outputs
//  that drive d0x0..d0x5 / d1x0..d1x5, so the display never shows a torn frame.
// PARAMETERS
//  NUM_BYTES       12          bytes per frame; slot order d0x0..d0x5, d1x0..d1x5
//  TIMEOUT_CYCLES  50_000_000  max idle gap between bytes inside a frame (1 s @ CLOCK_50)
// PORTS
//  iCLK         in   1   single clock (CLOCK_50 at top level)
//  iRST_N       in   1   reset, synchronous, active-low (KEY[0] at top level)
//  iDATA        in   8   stream byte
//  iVALID       in   1   iDATA valid
//  iSOF         in   1   start of frame, qualified by iVALID
//  oREADY       out  1   loader can accept a byte this cycle
//  oD0X0..oD0X5 out  8   committed row-0 bytes (each its own port)
//  oD1X0..oD1X5 out  8   committed row-1 bytes
//  oFRAME_CNT   out  8   committed-frame counter, wraps 255->0
//  oBUSY        out  1   high while in FILL or COMMIT
//  oERR         out  1   sticky: last frame aborted (timeout or resync)
// BEHAVIOUR
//  - Clock and reset: one clock, iCLK. Reset is synchronous and active-low
//    (iRST_N). Only sampled on a rising iCLK edge.
//  - Reset values: state IDLE, all oD*=8'h00, shadow=8'h00, index=0,
//    oFRAME_CNT=0, oERR=0, oBUSY=0, oREADY=1, timeout counter=0.
//  - Handshake: a byte is accepted on a rising edge when iVALID && oREADY.
//    iDATA and iSOF are sampled only on that edge.
//  - oREADY=1 in IDLE and FILL. oREADY=0 in COMMIT.
//  - FSM IDLE:
//    - accepted byte with iSOF=1: store it in shadow[0], set index=1, go to FILL.
//    - accepted byte with iSOF=0: drop it. No state change.
//  - FSM FILL:
//    - accepted byte with iSOF=0: store it in shadow[index], then index++.
//    - If that byte is shadow[NUM_BYTES-1], go to COMMIT.
//    - accepted byte with iSOF=1 (resync): store it in shadow[0], set index=1,
//      set oERR=1, stay in FILL.
//  - FSM COMMIT (exactly 1 cycle):
//    - copy shadow to all oD*, increment oFRAME_CNT, clear oERR.
//    - reset index to 0 and go to IDLE.
//  - Latency: new oD* and oFRAME_CNT are visible right after the edge that
//    follows the acceptance edge of the final byte (1 cycle).
//  - Timeout: the counter is cleared on every accepted byte and on leaving FILL.
//    It increments every FILL cycle with no acceptance.
//    - When it reaches TIMEOUT_CYCLES-1, go to IDLE and set oERR=1.
//    - oD* and oFRAME_CNT are unchanged; the partial shadow is discarded.
//  - Simultaneous events: an acceptance on the same edge as a timeout wins.
//    The byte is taken and the counter cleared.
//  - Mid-operation reset: on a reset edge all registers return to reset values,
//    including a COMMIT in progress (that commit is lost).
//  - Widths:
//    - index is $clog2(NUM_BYTES) bits.
//    - the timeout counter is $clog2(TIMEOUT_CYCLES) bits.
//    - oFRAME_CNT wraps modulo 256 with no saturation.
//  - No combinational path from iVALID/iDATA to any output. oREADY is a pure
//    function of the state.
// TESTING (bench uses TIMEOUT_CYCLES=16)
//  1. Reset, then 12 bytes 8'h30..8'h3B, iSOF on the first, back-to-back
//     -> one cycle later oD0X0=30..oD1X5=3B, oFRAME_CNT=1, oERR=0,
//     oREADY low exactly 1 cycle.
//  2. In IDLE, send 5 bytes with iSOF=0
//     -> all accepted and dropped, state IDLE, oD* and oFRAME_CNT unchanged.
//  3. After frame 1, send 4 bytes, then iSOF+12 bytes 8'h41..8'h4C
//     -> oERR=1 after the resync, then oD*=41..4C, oFRAME_CNT=2, oERR=0.
//  4. Send 6 bytes, then idle 16 cycles
//     -> IDLE, oERR=1, oD* still hold the previous frame.
//     Also: a byte arriving exactly on the timeout edge is accepted.
//  5. Assert iRST_N=0 during the COMMIT cycle
//     -> oD* stay 8'h00 and oFRAME_CNT=0 after reset.
//     Also: commit 256 frames -> oFRAME_CNT wraps to 0.
//  6. Hold iVALID=1 continuously across a commit
//     -> no byte is accepted in the COMMIT cycle, and the next frame starts
//     correctly on the following iSOF.

Source files
------------

// File: rtl/lcd_frame_loader.sv
// Byte-stream frame loader for the LCD character display: assembles a frame in a
// shadow buffer and commits it to the held display outputs in a single cycle.
`timescale 1ns/1ps

module lcd_frame_loader #(
  parameter int NUM_BYTES      = 12,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iDATA,
  input  logic       iVALID,
  input  logic       iSOF,
  output logic       oREADY,
  output logic [7:0] oD0X0,
  output logic [7:0] oD0X1,
  output logic [7:0] oD0X2,
  output logic [7:0] oD0X3,
  output logic [7:0] oD0X4,
  output logic [7:0] oD0X5,
  output logic [7:0] oD1X0,
  output logic [7:0] oD1X1,
  output logic [7:0] oD1X2,
  output logic [7:0] oD1X3,
  output logic [7:0] oD1X4,
  output logic [7:0] oD1X5,
  output logic [7:0] oFRAME_CNT,
  output logic       oBUSY,
  output logic       oERR
);

  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_COMMIT
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    shadow_q [NUM_BYTES];
  logic [7:0]    shadow_d [NUM_BYTES];
  logic [7:0]    disp_q   [NUM_BYTES];
  logic [7:0]    disp_d   [NUM_BYTES];
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          ready;
  logic          accept;

  assign ready  = (state_q != S_COMMIT);
  assign accept = iVALID && ready;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    shadow_d = shadow_q;
    disp_d   = disp_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        // Bytes without a start-of-frame marker are consumed and dropped.
        if (accept && iSOF) begin
          shadow_d[0] = iDATA;
          idx_d       = IW'(1);
          tmo_d       = '0;
          state_d     = S_FILL;
        end
      end

      S_FILL: begin
        if (accept) begin
          tmo_d = '0;
          if (iSOF) begin
            // Resync: restart the frame and flag the abandoned one.
            shadow_d[0] = iDATA;
            idx_d       = IW'(1);
            err_d       = 1'b1;
          end else begin
            shadow_d[idx_q] = iDATA;
            idx_d           = idx_q + IW'(1);
            if (idx_q == IW'(NUM_BYTES - 1)) begin
              state_d = S_COMMIT;
            end
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          idx_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_COMMIT: begin
        disp_d  = shadow_q;
        cnt_d   = cnt_q + 8'd1;
        err_d   = 1'b0;
        idx_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      // NOTE: the byte arrays are cleared on reset because the display must
      // read 00 after reset; these are small flop arrays, not a RAM macro.
      for (int i = 0; i < NUM_BYTES; i++) begin
        shadow_q[i] <= '0;
        disp_q[i]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge, independent of statement order.
      state_q  <= state_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
    end
  end

  // Slot order: row 0 columns 0..5, then row 1 columns 0..5.
  assign oD0X0 = disp_q[0];
  assign oD0X1 = disp_q[1];
  assign oD0X2 = disp_q[2];
  assign oD0X3 = disp_q[3];
  assign oD0X4 = disp_q[4];
  assign oD0X5 = disp_q[5];
  assign oD1X0 = disp_q[6];
  assign oD1X1 = disp_q[7];
  assign oD1X2 = disp_q[8];
  assign oD1X3 = disp_q[9];
  assign oD1X4 = disp_q[10];
  assign oD1X5 = disp_q[11];

  assign oFRAME_CNT = cnt_q;
  assign oREADY     = ready;
  assign oBUSY      = (state_q != S_IDLE);
  assign oERR       = err_q;

endmodule

// File: tb/tb_lcd_frame_loader.sv
// Self-checking bench for lcd_frame_loader: directed scenarios plus random traffic,
// with committed frames checked through a scoreboard fed by a byte-queue model.
`timescale 1ns/1ps

module tb_lcd_frame_loader;

  localparam int NB = 12;
  localparam int TO = 16;

  typedef struct packed {
    logic [NB*8-1:0] bytes;
    logic [7:0]      cnt;
  } frame_t;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic [7:0] iDATA = 8'h00;
  logic       iVALID = 1'b0;
  logic       iSOF = 1'b0;
  logic       oREADY, oBUSY, oERR;
  logic [7:0] oFRAME_CNT;
  logic [7:0] dout [NB];

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: a frame is just a growing list of bytes.
  logic [7:0]      m_buf [$];
  logic            m_filling = 1'b0;
  logic            m_pending = 1'b0;
  int              m_idle    = 0;
  logic            m_err     = 1'b0;
  logic [7:0]      m_cnt     = 8'd0;
  logic [NB*8-1:0] m_disp    = '0;
  frame_t          sb_q [$];

  logic   commit_seen = 1'b0;
  frame_t mon_f;

  lcd_frame_loader #(.NUM_BYTES(NB), .TIMEOUT_CYCLES(TO)) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iDATA     (iDATA),
    .iVALID    (iVALID),
    .iSOF      (iSOF),
    .oREADY    (oREADY),
    .oD0X0     (dout[0]),
    .oD0X1     (dout[1]),
    .oD0X2     (dout[2]),
    .oD0X3     (dout[3]),
    .oD0X4     (dout[4]),
    .oD0X5     (dout[5]),
    .oD1X0     (dout[6]),
    .oD1X1     (dout[7]),
    .oD1X2     (dout[8]),
    .oD1X3     (dout[9]),
    .oD1X4     (dout[10]),
    .oD1X5     (dout[11]),
    .oFRAME_CNT(oFRAME_CNT),
    .oBUSY     (oBUSY),
    .oERR      (oERR)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string name, input logic [NB*8-1:0] act, input logic [NB*8-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [NB*8-1:0] packed_disp();
    logic [NB*8-1:0] v;
    for (int i = 0; i < NB; i++) v[i*8 +: 8] = dout[i];
    return v;
  endfunction

  // One clock edge of the model, driven by exactly what the bench applied.
  function automatic void model_step(input logic v, input logic [7:0] d, input logic s, input logic rst);
    frame_t f;
    if (rst) begin
      m_buf.delete();
      m_filling = 1'b0;
      m_pending = 1'b0;
      m_idle    = 0;
      m_err     = 1'b0;
      m_cnt     = 8'd0;
      m_disp    = '0;
      return;
    end
    if (m_pending) begin
      for (int i = 0; i < NB; i++) f.bytes[i*8 +: 8] = m_buf[i];
      m_disp    = f.bytes;
      m_cnt     = m_cnt + 8'd1;
      f.cnt     = m_cnt;
      m_err     = 1'b0;
      m_pending = 1'b0;
      m_buf.delete();
      sb_q.push_back(f);
    end else if (v) begin
      if (s) begin
        if (m_filling) m_err = 1'b1;
        m_buf.delete();
        m_buf.push_back(d);
        m_filling = 1'b1;
        m_idle    = 0;
      end else if (m_filling) begin
        m_buf.push_back(d);
        m_idle = 0;
        if (m_buf.size() == NB) begin
          m_filling = 1'b0;
          m_pending = 1'b1;
        end
      end
    end else if (m_filling) begin
      if (m_idle == TO - 1) begin
        m_filling = 1'b0;
        m_err     = 1'b1;
        m_idle    = 0;
        m_buf.delete();
      end else begin
        m_idle++;
      end
    end
  endfunction

  task automatic tick(input logic v, input logic [7:0] d, input logic s, input logic rst_n);
    iVALID = v;
    iDATA  = d;
    iSOF   = s;
    iRST_N = rst_n;
    @(posedge iCLK);
    model_step(v, d, s, !rst_n);
    #1;
    check("ready", oREADY, !m_pending);
    check("busy", oBUSY, m_filling || m_pending);
    check("err", oERR, m_err);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_disp"}, packed_disp(), m_disp);
    check({tag, "_cnt"}, oFRAME_CNT, m_cnt);
  endtask

  task automatic send_frame(input logic [7:0] start);
    for (int i = 0; i < NB; i++) tick(1'b1, start + 8'(i), (i == 0), 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  // Monitor: a COMMIT cycle (ready low, reset released) is followed by new outputs.
  always @(negedge iCLK) begin
    if (commit_seen) begin
      commit_seen = 1'b0;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_commit at %0t: got cnt %0d expected no commit", $time, oFRAME_CNT);
      end else begin
        mon_f = sb_q.pop_front();
        check("frame_bytes", packed_disp(), mon_f.bytes);
        check("frame_cnt", oFRAME_CNT, mon_f.cnt);
      end
    end
    if (oREADY === 1'b0 && iRST_N) commit_seen = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of run expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    check_outputs("reset");
    check("reset_ready", oREADY, 1'b1);
    idle(2);

    // Back-to-back frame 30..3B.
    send_frame(8'h30);
    idle(2);
    check_outputs("frame1");
    check("frame1_cnt_abs", oFRAME_CNT, 8'd1);
    check("frame1_x0", dout[0], 8'h30);
    check("frame1_x11", dout[11], 8'h3B);

    // Non-SOF bytes in IDLE are dropped.
    for (int i = 0; i < 5; i++) tick(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b1);
    check_outputs("drop");

    // Partial frame, then resync with 41..4C.
    for (int i = 0; i < 4; i++) tick(1'b1, 8'h90 + 8'(i), (i == 0), 1'b1);
    send_frame(8'h41);
    idle(2);
    check_outputs("resync");
    check("resync_cnt_abs", oFRAME_CNT, 8'd2);

    // Timeout after 6 bytes.
    for (int i = 0; i < 6; i++) tick(1'b1, 8'hA0 + 8'(i), (i == 0), 1'b1);
    idle(TO);
    check_outputs("timeout");
    check("timeout_err", oERR, 1'b1);
    idle(3);

    // Byte on the timeout edge is still accepted.
    for (int i = 0; i < 4; i++) tick(1'b1, 8'hB0 + 8'(i), (i == 0), 1'b1);
    idle(TO - 1);
    for (int i = 4; i < NB; i++) tick(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b1);
    idle(2);
    check_outputs("edge_accept");

    // iVALID held high across a commit, next frame starts on SOF.
    send_frame(8'h50);
    tick(1'b1, 8'hAA, 1'b0, 1'b1);
    tick(1'b1, 8'hBB, 1'b0, 1'b1);
    send_frame(8'h60);
    tick(1'b1, 8'hCC, 1'b0, 1'b1);
    idle(2);
    check_outputs("valid_held");

    // Reset during the COMMIT cycle loses that commit.
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    idle(1);
    send_frame(8'h70);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    idle(2);
    check_outputs("rst_commit");
    check("rst_commit_x0", dout[0], 8'h00);

    // 256 frames wrap the counter back to 0.
    for (int k = 0; k < 256; k++) begin
      send_frame(8'($urandom));
      idle(1);
    end
    idle(1);
    check_outputs("wrap");
    check("wrap_cnt_abs", oFRAME_CNT, 8'd0);

    // Random traffic with occasional long gaps.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle(TO + $urandom_range(0, 4));
      end else begin
        tick(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 15) == 0), 1'b1);
      end
    end
    idle(3);
    check_outputs("random");
    check("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
